cpu_result_drain: RTL and testbench

- Consumer end of the cpu result/trap interface. Once the cpu halts or traps, the block pops the cpu result stack one value at a time.
- Each popped value, or a single trap record, is re-issued on a valid/ready output stream, ending with a terminating record.
- Sits between the cpu core and the host/test harness. It replaces ad-hoc sampling of `result`/`trap`.

---
 rtl/cpu_result_drain.sv | 119 +++++++++++
 tb/tb_cpu_result_drain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_result_drain.sv
// Drains the cpu result stack (or a single trap code) onto a valid/ready record stream.
// Latency: first record valid 2 cycles after cpu_done (1 after a trap); 3 cycles between value records.
// Backpressure: out_ready low holds the registered record stable; nothing is popped until it is accepted.
module cpu_result_drain #(
    parameter int MAX_RESULTS = 8,
    parameter int COUNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_done,
    input  logic [3:0]         trap,
    input  logic [63:0]        result,
    input  logic               result_empty,
    output logic               result_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_data,
    output logic [1:0]         out_kind,
    output logic               out_last,
    output logic [COUNT_W-1:0] count,
    output logic               busy
);

    localparam logic [1:0] KIND_VALUE    = 2'd0;
    localparam logic [1:0] KIND_TRAP     = 2'd1;
    localparam logic [1:0] KIND_END      = 2'd2;
    localparam logic [1:0] KIND_OVERFLOW = 2'd3;
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_RESULTS);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        EMIT,
        POP,
        SETTLE,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   handshake;

    assign handshake = (state == EMIT) && out_ready;

    // Strobes decode straight from the async-reset state register, so reset kills them at once.
    always_comb begin
        state_nxt  = state;
        out_valid  = 1'b0;
        result_pop = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trap != 4'd0) begin
                    state_nxt = EMIT;
                end else if (cpu_done) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: state_nxt = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = out_last ? DONE : POP;
                end
            end
            POP: begin
                result_pop = 1'b1;
                state_nxt  = SETTLE;
            end
            SETTLE: state_nxt = CHECK;
            DONE: busy = 1'b0;
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= 64'd0;
            out_kind <= KIND_VALUE;
            out_last <= 1'b0;
            count    <= '0;
        end else begin
            if (state == IDLE && trap != 4'd0) begin
                out_data <= {60'd0, trap};
                out_kind <= KIND_TRAP;
                out_last <= 1'b1;
            end else if (state == CHECK) begin
                if (result_empty) begin
                    out_data <= {{(64-COUNT_W){1'b0}}, count};
                    out_kind <= KIND_END;
                    out_last <= 1'b1;
                end else if (count == COUNT_MAX) begin
                    out_data <= {{(64-COUNT_W){1'b0}}, count};
                    out_kind <= KIND_OVERFLOW;
                    out_last <= 1'b1;
                end else begin
                    out_data <= result;
                    out_kind <= KIND_VALUE;
                    out_last <= 1'b0;
                end
            end
            if (handshake && !out_last && count != COUNT_MAX) begin
                count <= count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_result_drain.sv
// Directed bench for cpu_result_drain: a queue models the cpu result stack, two instances cover MAX_RESULTS 8 and 2.
module tb_cpu_result_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_done = 1'b0;
    logic [3:0]  trap = 4'd0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;
    logic [63:0] result = 64'd0;
    logic        result_empty = 1'b1;

    logic        pop_a, vld_a, last_a, busy_a;
    logic [63:0] dat_a;
    logic [1:0]  kind_a;
    logic [3:0]  cnt_a;
    logic        pop_b, vld_b, last_b, busy_b;
    logic [63:0] dat_b;
    logic [1:0]  kind_b;
    logic [3:0]  cnt_b;

    logic        done_a, done_b;
    logic [3:0]  trap_a, trap_b;
    assign done_a = cpu_done & ~sel;
    assign done_b = cpu_done & sel;
    assign trap_a = sel ? 4'd0 : trap;
    assign trap_b = sel ? trap : 4'd0;

    cpu_result_drain #(.MAX_RESULTS(8), .COUNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .cpu_done(done_a), .trap(trap_a),
        .result(result), .result_empty(result_empty), .result_pop(pop_a),
        .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a),
        .out_kind(kind_a), .out_last(last_a), .count(cnt_a), .busy(busy_a)
    );

    cpu_result_drain #(.MAX_RESULTS(2), .COUNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .cpu_done(done_b), .trap(trap_b),
        .result(result), .result_empty(result_empty), .result_pop(pop_b),
        .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b),
        .out_kind(kind_b), .out_last(last_b), .count(cnt_b), .busy(busy_b)
    );

    logic        pop_m, vld_m, last_m, busy_m;
    logic [63:0] dat_m;
    logic [1:0]  kind_m;
    logic [3:0]  cnt_m;
    assign pop_m  = sel ? pop_b  : pop_a;
    assign vld_m  = sel ? vld_b  : vld_a;
    assign last_m = sel ? last_b : last_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign dat_m  = sel ? dat_b  : dat_a;
    assign kind_m = sel ? kind_b : kind_a;
    assign cnt_m  = sel ? cnt_b  : cnt_a;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int npops = 0;
    int pop_empty = 0;
    logic [63:0] stk[$];
    logic [63:0] rec_d[$];
    logic [1:0]  rec_k[$];
    logic        rec_l[$];
    logic [63:0] tmp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic upd();
        result_empty = (stk.size() == 0);
        result       = (stk.size() == 0) ? 64'd0 : stk[stk.size()-1];
    endtask

    task automatic push(input logic [63:0] v);
        stk.push_back(v);
        upd();
    endtask

    // Stack model: the pop strobe is seen mid-cycle and the new top is ready before the following edge.
    always @(negedge clk) begin
        if (pop_m) begin
            if (stk.size() == 0) begin
                pop_empty++;
            end else begin
                tmp = stk.pop_back();
            end
            npops++;
            upd();
        end
        if (vld_m && out_ready && reset) begin
            rec_d.push_back(dat_m);
            rec_k.push_back(kind_m);
            rec_l.push_back(last_m);
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        cpu_done = 1'b0;
        trap = 4'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stk.delete();
        upd();
        rec_d.delete();
        rec_k.delete();
        rec_l.delete();
        npops = 0;
        pop_empty = 0;
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rec(input string tag, input int i, input logic [1:0] k,
                           input logic [63:0] d, input logic l);
        if (rec_d.size() > i) begin
            chk({tag, "_kind"}, 64'(rec_k[i]), 64'(k));
            chk({tag, "_data"}, rec_d[i], d);
            chk({tag, "_last"}, 64'(rec_l[i]), 64'(l));
        end else begin
            chk({tag, "_missing"}, 64'(rec_d.size()), 64'(i + 1));
        end
    endtask

    int bad;

    initial begin
        // Reset state
        reset = 1'b0;
        #12;
        chk("rst_valid", 64'(vld_a), 0);
        chk("rst_pop", 64'(pop_a), 0);
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_count", 64'(cnt_a), 0);
        chk("rst_data", dat_a, 0);
        chk("rst_kind", 64'(kind_a), 0);
        chk("rst_last", 64'(last_a), 0);

        // Two-value drain
        do_reset();
        push(64'd42);
        push(64'd7);
        run(1);
        cpu_done = 1'b1;
        run(30);
        chk("t1_nrec", 64'(rec_d.size()), 3);
        chk_rec("t1_r0", 0, 2'd0, 64'd7, 1'b0);
        chk_rec("t1_r1", 1, 2'd0, 64'd42, 1'b0);
        chk_rec("t1_r2", 2, 2'd2, 64'd2, 1'b1);
        chk("t1_pops", 64'(npops), 2);
        chk("t1_count", 64'(cnt_a), 2);
        chk("t1_done_busy", 64'(busy_m), 0);
        chk("t1_done_valid", 64'(vld_m), 0);

        // Trap wins over cpu_done on the same edge
        do_reset();
        push(64'd99);
        run(1);
        trap = 4'd5;
        cpu_done = 1'b1;
        run(1);
        chk("t2_lat_valid", 64'(vld_m), 1);
        run(20);
        chk("t2_nrec", 64'(rec_d.size()), 1);
        chk_rec("t2_r0", 0, 2'd1, 64'd5, 1'b1);
        chk("t2_pops", 64'(npops), 0);
        chk("t2_count", 64'(cnt_m), 0);

        // Empty stack: end record two cycles after trigger
        do_reset();
        run(1);
        cpu_done = 1'b1;
        run(1);
        chk("t3_lat1_valid", 64'(vld_m), 0);
        chk("t3_lat1_busy", 64'(busy_m), 1);
        run(1);
        chk("t3_lat2_valid", 64'(vld_m), 1);
        chk("t3_kind", 64'(kind_m), 2);
        chk("t3_data", dat_m, 0);
        chk("t3_last", 64'(last_m), 1);
        run(10);
        chk("t3_nrec", 64'(rec_d.size()), 1);
        chk("t3_pops", 64'(npops), 0);

        // Backpressure on the first value record
        do_reset();
        push(64'd42);
        push(64'd7);
        out_ready = 1'b0;
        run(1);
        cpu_done = 1'b1;
        run(2);
        chk("t4_valid_up", 64'(vld_m), 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!vld_m || dat_m !== 64'd7 || kind_m !== 2'd0 || last_m !== 1'b0 || pop_m)
                bad++;
        end
        chk("t4_held_stable", 64'(bad), 0);
        chk("t4_no_pop", 64'(npops), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        run(1);
        chk("t4_accept_nrec", 64'(rec_d.size()), 1);
        chk("t4_pop_strobe", 64'(pop_m), 1);
        chk("t4_valid_drop", 64'(vld_m), 0);
        run(30);
        chk("t4_nrec", 64'(rec_d.size()), 3);
        chk_rec("t4_r0", 0, 2'd0, 64'd7, 1'b0);
        chk_rec("t4_r2", 2, 2'd2, 64'd2, 1'b1);

        // Overflow with MAX_RESULTS=2
        sel = 1'b1;
        do_reset();
        push(64'd1);
        push(64'd2);
        push(64'd3);
        run(1);
        cpu_done = 1'b1;
        run(30);
        chk("t5_nrec", 64'(rec_d.size()), 3);
        chk_rec("t5_r0", 0, 2'd0, 64'd3, 1'b0);
        chk_rec("t5_r1", 1, 2'd0, 64'd2, 1'b0);
        chk_rec("t5_r2", 2, 2'd3, 64'd2, 1'b1);
        chk("t5_pops", 64'(npops), 2);
        chk("t5_count", 64'(cnt_m), 2);
        chk("t5_stack_left", 64'(stk.size()), 1);

        // Reset during the POP cycle
        sel = 1'b0;
        do_reset();
        push(64'd42);
        push(64'd7);
        run(1);
        cpu_done = 1'b1;
        bad = 1;
        for (int i = 0; i < 50 && bad != 0; i++) begin
            @(negedge clk);
            if (pop_m) bad = 0;
        end
        chk("t6_pop_seen", 64'(bad), 0);
        #1;
        reset = 1'b0;
        cpu_done = 1'b0;
        #1;
        chk("t6_pop_drop", 64'(pop_m), 0);
        chk("t6_valid_drop", 64'(vld_m), 0);
        chk("t6_busy_drop", 64'(busy_m), 0);
        run(2);
        reset = 1'b1;
        rec_d.delete();
        rec_k.delete();
        rec_l.delete();
        run(10);
        chk("t6_idle_busy", 64'(busy_m), 0);
        chk("t6_idle_nrec", 64'(rec_d.size()), 0);
        cpu_done = 1'b1;
        run(30);
        chk("t6_rerun_nrec", 64'(rec_d.size()), 2);
        chk_rec("t6_r0", 0, 2'd0, 64'd42, 1'b0);
        chk_rec("t6_r1", 1, 2'd2, 64'd1, 1'b1);
        chk("t6_count", 64'(cnt_m), 1);
        chk("pop_while_empty", 64'(pop_empty), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
